// File: rtl/sw_pkg.sv
// Shared constants for the switch conditioning path.
package sw_pkg;

   localparam int unsigned SW_WIDTH           = 24;
   localparam int unsigned SW_SYNC_STAGES     = 2;
   localparam int unsigned SW_TICK_DIV_100MHZ = 100000;
   localparam int unsigned SW_STABLE_CNT      = 8;

   // Width of a counter that holds 0..n-1, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser chain, agreement counter and accept logic.
module debounce_bit
   import sw_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SW_SYNC_STAGES,
   parameter int unsigned STABLE_CNT  = SW_STABLE_CNT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic db,
   output logic db_next
);

   localparam int unsigned CntW = cnt_width(STABLE_CNT);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   db_q, db_d;
   logic                   sw_sync;

   assign sw_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw};
      cnt_d  = cnt_q;
      db_d   = db_q;
      if (tick) begin
         if (sw_sync == db_q) begin
            cnt_d = '0;
         end else if (cnt_q == CntW'(STABLE_CNT - 1)) begin
            db_d  = sw_sync;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         db_q   <= db_d;
      end
   end

   assign db      = db_q;
   // Exposed so the top can register a change pulse aligned with the new db.
   assign db_next = db_d;

endmodule

// File: rtl/switch_debounce.sv
// Debounced DIP-switch vector with change pulse; SW_IRQ_EN adds a sticky
// irq_pending flag cleared by irq_clr.
module switch_debounce
   import sw_pkg::*;
#(
   parameter int unsigned WIDTH       = SW_WIDTH,
   parameter int unsigned SYNC_STAGES = SW_SYNC_STAGES,
   parameter int unsigned TICK_DIV    = SW_TICK_DIV_100MHZ,
   parameter int unsigned STABLE_CNT  = SW_STABLE_CNT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_db,
   output logic             sw_changed,
   input  logic             irq_clr,
   output logic             irq_pending
);

   localparam int unsigned PreW = cnt_width(TICK_DIV);

   logic [PreW-1:0]  pre_q, pre_d;
   logic             tick;
   logic [WIDTH-1:0] db_next;
   logic             sw_changed_q, sw_changed_d;

   assign tick = (pre_q == PreW'(TICK_DIV - 1));

   always_comb begin
      pre_d        = tick ? '0 : pre_q + 1'b1;
      sw_changed_d = (db_next != sw_db);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q        <= '0;
         sw_changed_q <= 1'b0;
      end else begin
         pre_q        <= pre_d;
         sw_changed_q <= sw_changed_d;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .STABLE_CNT  (STABLE_CNT)
      ) u_bit (
         .clk     (clk),
         .rst_n   (rst_n),
         .tick    (tick),
         .raw     (sw_raw[i]),
         .db      (sw_db[i]),
         .db_next (db_next[i])
      );
   end

   assign sw_changed = sw_changed_q;

`ifdef SW_IRQ_EN
   logic irq_q, irq_d;

   // A new change outranks a simultaneous clear so no event is lost.
   always_comb begin
      irq_d = irq_q;
      if (sw_changed_q) begin
         irq_d = 1'b1;
      end else if (irq_clr) begin
         irq_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq_pending = irq_q;
`else
   logic unused_irq_clr;
   assign unused_irq_clr = irq_clr;
   assign irq_pending    = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed scenarios plus random switch activity,
// all cross-checked cycle by cycle against a behavioural model.
module tb_switch_debounce;

   localparam int unsigned W  = 24;
   localparam int unsigned S  = 2;
   localparam int unsigned TD = 4;
   localparam int unsigned SC = 3;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] sw_raw;
   logic [W-1:0] sw_db;
   logic         sw_changed;
   logic         irq_clr;
   logic         irq_pending;

   int n_checks = 0;
   int n_pass   = 0;
   bit model_ready = 0;

   switch_debounce #(
      .WIDTH       (W),
      .SYNC_STAGES (S),
      .TICK_DIV    (TD),
      .STABLE_CNT  (SC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sw_raw      (sw_raw),
      .sw_db       (sw_db),
      .sw_changed  (sw_changed),
      .irq_clr     (irq_clr),
      .irq_pending (irq_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // Behavioural model: the pad value seen S clocks late is sampled every TD
   // clocks; a bit adopts the sampled level after SC disagreeing samples in a row.
   logic [W-1:0] m_hist [S];
   logic [W-1:0] m_db;
   int           m_run [W];
   int           m_pre;
   logic         m_chg;
   logic         m_irq;

   always @(posedge clk or negedge rst_n) begin : model
      logic [W-1:0] sync_now;
      logic [W-1:0] new_db;
      logic         tick;
      int           run_n [W];
      if (!rst_n) begin
         for (int s = 0; s < S; s++) m_hist[s] <= '0;
         for (int i = 0; i < W; i++) m_run[i] <= 0;
         m_db  <= '0;
         m_pre <= 0;
         m_chg <= 1'b0;
         m_irq <= 1'b0;
      end else begin
         sync_now = m_hist[S-1];
         tick     = (m_pre == TD - 1);
         new_db   = m_db;
         for (int i = 0; i < W; i++) begin
            run_n[i] = m_run[i];
            if (tick) begin
               if (sync_now[i] != m_db[i]) begin
                  run_n[i] = run_n[i] + 1;
                  if (run_n[i] == SC) begin
                     new_db[i] = sync_now[i];
                     run_n[i]  = 0;
                  end
               end else begin
                  run_n[i] = 0;
               end
            end
            m_run[i] <= run_n[i];
         end
         m_pre     <= (m_pre + 1) % TD;
         m_hist[0] <= sw_raw;
         for (int s = 1; s < S; s++) m_hist[s] <= m_hist[s-1];
         m_db  <= new_db;
         m_chg <= (new_db != m_db);
`ifdef SW_IRQ_EN
         if (m_chg) m_irq <= 1'b1;
         else if (irq_clr) m_irq <= 1'b0;
`endif
      end
   end

   always @(posedge clk) begin
      #1;
      if (model_ready) begin
         check_val("model_db", 32'(sw_db), 32'(m_db));
         check_val("model_chg", 32'(sw_changed), 32'(m_chg));
         check_val("model_irq", 32'(irq_pending), 32'(m_irq));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Watch n cycles: first cycle sw_db equals target, pulse count and positions.
   task automatic measure(input logic [W-1:0] target, input int n, output int lat,
                          output int pulses, output int first_p, output int last_p);
      lat = 0; pulses = 0; first_p = 0; last_p = 0;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (sw_db == target && lat == 0) lat = c;
         if (sw_changed) begin
            pulses++;
            if (first_p == 0) first_p = c;
            last_p = c;
         end
      end
   endtask

   initial begin
      int lat, pulses, fp, lp;
      bit seen;
      rst_n   = 1'b0;
      sw_raw  = '1;
      irq_clr = 1'b0;

      // 1: reset state, then the all-ones pad level is adopted once
      cyc(3);
      check_val("t1_rst_db", 32'(sw_db), 32'h0);
      check_val("t1_rst_chg", 32'(sw_changed), 32'h0);
      check_val("t1_rst_irq", 32'(irq_pending), 32'h0);
      model_ready = 1;
      rst_n = 1'b1;
      measure('1, 20, lat, pulses, fp, lp);
      check_val("t1_lat_ok", 32'(lat != 0 && lat <= 15), 32'h1);
      check_val("t1_pulses", 32'(pulses), 32'h1);

      // 2: clean step
      sw_raw = '0;
      cyc(20);
      sw_raw = 24'h00A5A5;
      measure(24'h00A5A5, 25, lat, pulses, fp, lp);
      check_val("t2_lat_ok", 32'(lat >= 11 && lat <= 15), 32'h1);
      check_val("t2_pulses", 32'(pulses), 32'h1);
      check_val("t2_db", 32'(sw_db), 32'h00A5A5);

      // 3: short pulses on bit 0 are rejected
      sw_raw = '0;
      cyc(20);
      pulses = 0;
      repeat (4) begin
         sw_raw[0] = 1'b1;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (sw_changed) pulses++;
         end
         sw_raw[0] = 1'b0;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (sw_changed) pulses++;
         end
      end
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (sw_changed) pulses++;
      end
      check_val("t3_db", 32'(sw_db), 32'h0);
      check_val("t3_pulses", 32'(pulses), 32'h0);

      // 4: two bits rising four cycles apart give two separate pulses
      sw_raw[3] = 1'b1;
      cyc(4);
      sw_raw[20] = 1'b1;
      measure(24'h100008, 30, lat, pulses, fp, lp);
      check_val("t4_pulses", 32'(pulses), 32'h2);
      check_val("t4_gap", 32'(lp - fp), 32'h4);
      check_val("t4_db", 32'(sw_db), 32'h100008);

      // 5: reset mid-count restarts the full window
      sw_raw = '0;
      cyc(20);
      sw_raw = 24'h000001;
      cyc(8);
      rst_n = 1'b0;
      cyc(1);
      check_val("t5_rst_db", 32'(sw_db), 32'h0);
      check_val("t5_rst_chg", 32'(sw_changed), 32'h0);
      cyc(1);
      rst_n = 1'b1;
      measure(24'h000001, 25, lat, pulses, fp, lp);
      check_val("t5_lat_ok", 32'(lat >= 11 && lat <= 15), 32'h1);
      check_val("t5_pulses", 32'(pulses), 32'h1);

      // 6: sticky flag behaviour
`ifdef SW_IRQ_EN
      check_val("t6_irq_set", 32'(irq_pending), 32'h1);
      irq_clr = 1'b1;
      cyc(1);
      irq_clr = 1'b0;
      check_val("t6_irq_clr", 32'(irq_pending), 32'h0);
      sw_raw = '0;
      seen = 0;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(negedge clk);
         if (sw_changed) seen = 1;
      end
      check_val("t6_seen", 32'(seen), 32'h1);
      irq_clr = 1'b1;
      cyc(1);
      irq_clr = 1'b0;
      check_val("t6_set_wins", 32'(irq_pending), 32'h1);
      irq_clr = 1'b1;
      cyc(1);
      irq_clr = 1'b0;
      check_val("t6_clr_only", 32'(irq_pending), 32'h0);
`else
      seen = 0;
      check_val("t6_irq_tied", 32'(irq_pending), 32'h0);
      irq_clr = 1'b1;
      cyc(1);
      irq_clr = 1'b0;
      check_val("t6_irq_tied2", 32'(irq_pending), 32'h0);
`endif

      // Random phase: held values, short bounces and stray clears
      for (int it = 0; it < 40; it++) begin
         int hold;
         case ($urandom_range(0, 2))
            0: begin
               sw_raw = W'($urandom);
            end
            1: begin
               logic [W-1:0] keep;
               keep   = sw_raw;
               sw_raw = sw_raw ^ W'($urandom);
               cyc($urandom_range(1, 6));
               sw_raw = keep;
            end
            default: begin
               sw_raw[$urandom_range(0, W - 1)] ^= 1'b1;
            end
         endcase
         hold = $urandom_range(5, 40);
         for (int c = 0; c < hold; c++) begin
            irq_clr = ($urandom_range(0, 7) == 0);
            @(negedge clk);
         end
         irq_clr = 1'b0;
      end

      cyc(5);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
